writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 141 ++++++++++++++
 tb/tb_writeback_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Writeback queue: buffers up to two results per cycle and retires up to two per cycle to the register file.
// Optional macro WRITEBACK_QUEUE_BYPASS_EN enables queued-data forwarding on queryValue1..4.
module writeback_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enqValid1,
    input  logic                     enqValid2,
    input  logic [4:0]               enqAddr1,
    input  logic [4:0]               enqAddr2,
    input  logic [31:0]              enqData1,
    input  logic [31:0]              enqData2,
    output logic                     enqReady,
    input  logic                     drainStall,
    output logic                     writeEnable1,
    output logic                     writeEnable2,
    output logic [4:0]               addressForWriting1,
    output logic [4:0]               addressForWriting2,
    output logic [31:0]              valueForWriting1,
    output logic [31:0]              valueForWriting2,
    input  logic [4:0]               queryAddr1,
    input  logic [4:0]               queryAddr2,
    input  logic [4:0]               queryAddr3,
    input  logic [4:0]               queryAddr4,
    output logic                     queryPending1,
    output logic                     queryPending2,
    output logic                     queryPending3,
    output logic                     queryPending4,
    output logic [31:0]              queryValue1,
    output logic [31:0]              queryValue2,
    output logic [31:0]              queryValue3,
    output logic [31:0]              queryValue4,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_acc1;
    logic          w_acc2;
    logic [1:0]    w_nenq;
    logic [1:0]    w_ndrain;
    logic [AW-1:0] w_head1;
    logic [AW-1:0] w_tail2;
    logic          w_has1;
    logic          w_has2;
    logic          w_same;
    logic [4:0]    w_qaddr [4];
    logic [3:0]    w_qpend;
    logic [31:0]   w_qval  [4];

    // Credit comes from registered occupancy only, so a same-cycle drain never frees space early.
    assign enqReady = (CW'(DEPTH) - r_count) >= CW'(2);
    assign w_acc1   = enqReady && enqValid1 && (enqAddr1 != 5'd0);
    assign w_acc2   = enqReady && enqValid2 && (enqAddr2 != 5'd0);
    assign w_nenq   = {1'b0, w_acc1} + {1'b0, w_acc2};
    assign w_tail2  = r_tail + AW'(w_acc1);

    assign w_head1  = r_head + AW'(1);
    assign w_has1   = (r_count != '0);
    assign w_has2   = (r_count >= CW'(2));
    // The older of two same-address writes is dead; retire it silently.
    assign w_same   = w_has2 && (r_addr[r_head] == r_addr[w_head1]);
    assign w_ndrain = drainStall ? 2'd0 : (w_has2 ? 2'd2 : (w_has1 ? 2'd1 : 2'd0));

    assign writeEnable1       = w_has1 && !drainStall && !w_same;
    assign writeEnable2       = w_has2 && !drainStall;
    assign addressForWriting1 = writeEnable1 ? r_addr[r_head]  : 5'd0;
    assign valueForWriting1   = writeEnable1 ? r_data[r_head]  : 32'd0;
    assign addressForWriting2 = writeEnable2 ? r_addr[w_head1] : 5'd0;
    assign valueForWriting2   = writeEnable2 ? r_data[w_head1] : 32'd0;

    assign count = r_count;
    assign empty = (r_count == '0);

    always_ff @(posedge clock) begin
        if (w_acc1) begin
            r_addr[r_tail] <= enqAddr1;
            r_data[r_tail] <= enqData1;
        end
        if (w_acc2) begin
            r_addr[w_tail2] <= enqAddr2;
            r_data[w_tail2] <= enqData2;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_ndrain);
            r_tail  <= r_tail + AW'(w_nenq);
            r_count <= r_count + CW'(w_nenq) - CW'(w_ndrain);
        end
    end

    assign w_qaddr[0] = queryAddr1;
    assign w_qaddr[1] = queryAddr2;
    assign w_qaddr[2] = queryAddr3;
    assign w_qaddr[3] = queryAddr4;

    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [AW-1:0] v_idx;
        v_idx = '0;
        for (int q = 0; q < 4; q++) begin
            w_qpend[q] = 1'b0;
            w_qval[q]  = 32'd0;
            for (int k = 0; k < DEPTH; k++) begin
                v_idx = r_head + AW'(k);
                if ((CW'(k) < r_count) && (w_qaddr[q] != 5'd0) && (r_addr[v_idx] == w_qaddr[q])) begin
                    w_qpend[q] = 1'b1;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
                    w_qval[q]  = r_data[v_idx];
`else
                    w_qval[q]  = 32'd0;
`endif
                end
            end
        end
    end

    assign queryPending1 = w_qpend[0];
    assign queryPending2 = w_qpend[1];
    assign queryPending3 = w_qpend[2];
    assign queryPending4 = w_qpend[3];
    assign queryValue1   = w_qval[0];
    assign queryValue2   = w_qval[1];
    assign queryValue3   = w_qval[2];
    assign queryValue4   = w_qval[3];

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_writeback_queue;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enqValid1 = 1'b0, enqValid2 = 1'b0;
    logic [4:0]  enqAddr1 = '0, enqAddr2 = '0;
    logic [31:0] enqData1 = '0, enqData2 = '0;
    logic        enqReady;
    logic        drainStall = 1'b0;
    logic        writeEnable1, writeEnable2;
    logic [4:0]  addressForWriting1, addressForWriting2;
    logic [31:0] valueForWriting1, valueForWriting2;
    logic [4:0]  queryAddr1 = '0, queryAddr2 = '0, queryAddr3 = '0, queryAddr4 = '0;
    logic        queryPending1, queryPending2, queryPending3, queryPending4;
    logic [31:0] queryValue1, queryValue2, queryValue3, queryValue4;
    logic [3:0]  count;
    logic        empty;

    typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
    wr_t sb[$];
    int checks = 0;
    int failures = 0;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .enqValid1(enqValid1), .enqValid2(enqValid2),
        .enqAddr1(enqAddr1), .enqAddr2(enqAddr2),
        .enqData1(enqData1), .enqData2(enqData2),
        .enqReady(enqReady), .drainStall(drainStall),
        .writeEnable1(writeEnable1), .writeEnable2(writeEnable2),
        .addressForWriting1(addressForWriting1), .addressForWriting2(addressForWriting2),
        .valueForWriting1(valueForWriting1), .valueForWriting2(valueForWriting2),
        .queryAddr1(queryAddr1), .queryAddr2(queryAddr2),
        .queryAddr3(queryAddr3), .queryAddr4(queryAddr4),
        .queryPending1(queryPending1), .queryPending2(queryPending2),
        .queryPending3(queryPending3), .queryPending4(queryPending4),
        .queryValue1(queryValue1), .queryValue2(queryValue2),
        .queryValue3(queryValue3), .queryValue4(queryValue4),
        .count(count), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_port(input string p, input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_write actual addr=%0d data=0x%0h required no write", p, a, d);
        end else begin
            e = sb.pop_front();
            chk({p, "_addr"}, 32'(a), 32'(e.a));
            chk({p, "_data"}, d, e.d);
        end
    endtask

    // Port 1 is the older write, so it is consumed first.
    always @(negedge clock) begin
        if (writeEnable1) mon_port("port1", addressForWriting1, valueForWriting1);
        if (writeEnable2) mon_port("port2", addressForWriting2, valueForWriting2);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic v2, input logic [4:0] a2, input logic [31:0] d2);
        enqValid1 = v1; enqAddr1 = a1; enqData1 = d1;
        enqValid2 = v2; enqAddr2 = a2; enqData2 = d2;
        tick();
        enqValid1 = 1'b0; enqValid2 = 1'b0;
        enqAddr1 = '0; enqAddr2 = '0; enqData1 = '0; enqData2 = '0;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        sb.push_back('{a: a, d: d});
    endtask

    initial begin
        logic [31:0] exp_bypass;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_we1", 32'(writeEnable1), 32'd0);
        chk("rst_we2", 32'(writeEnable2), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_enqReady", 32'(enqReady), 32'd1);
        reset = 1'b0;

        // Basic two-lane enqueue, drained next cycle
        push(5'd5, 32'hAAAA); push(5'd6, 32'hBBBB);
        drive(1, 5'd5, 32'hAAAA, 1, 5'd6, 32'hBBBB);
        chk("basic_we1", 32'(writeEnable1), 32'd1);
        chk("basic_we2", 32'(writeEnable2), 32'd1);
        chk("basic_count2", 32'(count), 32'd2);
        tick();
        chk("basic_count0", 32'(count), 32'd0);
        chk("basic_empty", 32'(empty), 32'd1);

        // Same-address pair: only the younger write survives on port 2
        push(5'd7, 32'h2);
        drive(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
        chk("same_we1", 32'(writeEnable1), 32'd0);
        chk("same_we2", 32'(writeEnable2), 32'd1);
        chk("same_count2", 32'(count), 32'd2);
        tick();
        chk("same_count0", 32'(count), 32'd0);

        // Lane 1 to r0 discarded; lane 2 stored alone
        drainStall = 1'b1;
        push(5'd3, 32'h33);
        drive(1, 5'd0, 32'h99, 1, 5'd3, 32'h33);
        chk("r0_count", 32'(count), 32'd1);
        queryAddr1 = 5'd0; queryAddr2 = 5'd3;
        #1;
        chk("r0_pend_addr0", 32'(queryPending1), 32'd0);
        chk("r0_pend_addr3", 32'(queryPending2), 32'd1);
`ifdef WRITEBACK_QUEUE_BYPASS_EN
        exp_bypass = 32'h33;
`else
        exp_bypass = 32'h0;
`endif
        chk("r0_qval_addr3", queryValue2, exp_bypass);
        chk("r0_stall_we1", 32'(writeEnable1), 32'd0);
        drainStall = 1'b0;
        #1;
        chk("r0_we1", 32'(writeEnable1), 32'd1);
        chk("r0_we2", 32'(writeEnable2), 32'd0);
        tick();
        chk("r0_count0", 32'(count), 32'd0);
        queryAddr1 = '0; queryAddr2 = '0;

        // Fill to 7 under stall: one free slot is not enough credit
        drainStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(5'(10 + 2 * i), 32'h100 + 32'(2 * i));
            push(5'(11 + 2 * i), 32'h101 + 32'(2 * i));
            drive(1, 5'(10 + 2 * i), 32'h100 + 32'(2 * i), 1, 5'(11 + 2 * i), 32'h101 + 32'(2 * i));
        end
        chk("f7_ready_at6", 32'(enqReady), 32'd1);
        push(5'd16, 32'h106);
        drive(1, 5'd16, 32'h106, 0, 5'd0, 32'h0);
        chk("f7_count", 32'(count), 32'd7);
        chk("f7_ready", 32'(enqReady), 32'd0);
        drive(1, 5'd30, 32'hDEAD, 1, 5'd31, 32'hBEEF);
        chk("f7_drop_count", 32'(count), 32'd7);
        drainStall = 1'b0;
        tick(); chk("f7_drain_5", 32'(count), 32'd5);
        tick(); chk("f7_drain_3", 32'(count), 32'd3);
        tick(); chk("f7_drain_1", 32'(count), 32'd1);
        tick(); chk("f7_drain_0", 32'(count), 32'd0);

        // Fill to DEPTH, drop extra lanes, drain 8 in 4 cycles
        drainStall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(5'(10 + 2 * i), 32'h200 + 32'(2 * i));
            push(5'(11 + 2 * i), 32'h201 + 32'(2 * i));
            drive(1, 5'(10 + 2 * i), 32'h200 + 32'(2 * i), 1, 5'(11 + 2 * i), 32'h201 + 32'(2 * i));
        end
        chk("f8_count", 32'(count), 32'd8);
        chk("f8_ready", 32'(enqReady), 32'd0);
        drive(1, 5'd30, 32'hDEAD, 1, 5'd31, 32'hBEEF);
        chk("f8_drop_count", 32'(count), 32'd8);
        drainStall = 1'b0;
        tick(); chk("f8_drain_6", 32'(count), 32'd6);
        tick(); chk("f8_drain_4", 32'(count), 32'd4);
        tick(); chk("f8_drain_2", 32'(count), 32'd2);
        tick(); chk("f8_drain_0", 32'(count), 32'd0);

        // Simultaneous enqueue and drain keeps occupancy steady
        push(5'd1, 32'h11); push(5'd2, 32'h22);
        drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
        push(5'd3, 32'h44); push(5'd4, 32'h55);
        drive(1, 5'd3, 32'h44, 1, 5'd4, 32'h55);
        chk("simul_count", 32'(count), 32'd2);
        tick();
        chk("simul_count0", 32'(count), 32'd0);

        // Youngest match bypass
        drainStall = 1'b1;
        drive(1, 5'd9, 32'h10, 0, 5'd0, 32'h0);
        drive(1, 5'd9, 32'h20, 0, 5'd0, 32'h0);
        push(5'd9, 32'h20);
        queryAddr3 = 5'd9; queryAddr4 = 5'd8;
        #1;
        chk("byp_pend9", 32'(queryPending3), 32'd1);
        chk("byp_pend8", 32'(queryPending4), 32'd0);
`ifdef WRITEBACK_QUEUE_BYPASS_EN
        exp_bypass = 32'h20;
`else
        exp_bypass = 32'h0;
`endif
        chk("byp_val9", queryValue3, exp_bypass);
        chk("byp_val8", queryValue4, 32'h0);
        drainStall = 1'b0;
        #1;
        chk("byp_we1", 32'(writeEnable1), 32'd0);
        chk("byp_we2", 32'(writeEnable2), 32'd1);
        tick();
        chk("byp_count0", 32'(count), 32'd0);
        queryAddr3 = '0; queryAddr4 = '0;

        // Mid-operation reset drops four queued writes
        drainStall = 1'b1;
        drive(1, 5'd20, 32'h1, 1, 5'd21, 32'h2);
        drive(1, 5'd22, 32'h3, 1, 5'd23, 32'h4);
        chk("mrst_count4", 32'(count), 32'd4);
        queryAddr1 = 5'd20;
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("mrst_we1", 32'(writeEnable1), 32'd0);
        chk("mrst_we2", 32'(writeEnable2), 32'd0);
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_ready", 32'(enqReady), 32'd1);
        chk("mrst_pend", 32'(queryPending1), 32'd0);
        drainStall = 1'b0;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("mrst_after_count", 32'(count), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
